// File: rtl/tdc_meas_ctrl.sv
// ============================================================================
// Module   : tdc_meas_ctrl
// Brief    : TDC measurement sequencer; accumulates 2^LOG_SAMPLES tap counts
//            into sum/min/max. Option: TDC_MEAS_CTRL_BUBBLE_FIX_EN (popcount).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_meas_ctrl #(
  parameter int DATA_WIDTH     = 252,
  parameter int CNT_WIDTH      = 8,
  parameter int LOG_SAMPLES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CAPTURE_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [CNT_WIDTH+LOG_SAMPLES-1:0] resp_sum,
  output logic [CNT_WIDTH-1:0]             resp_min,
  output logic [CNT_WIDTH-1:0]             resp_max,
  output logic                             resp_bubble,
  output logic                             resp_ovf,
  output logic                             busy,
  output logic                             tdc_reset_b,
  output logic                             tdc_start,
  input  logic [DATA_WIDTH-1:0]            tdc_dout
);

  localparam int c_sum_w   = CNT_WIDTH + LOG_SAMPLES;
  localparam int c_tmr_max = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
  localparam int c_idx_w   = (LOG_SAMPLES > 0) ? LOG_SAMPLES : 1;
  localparam logic [c_idx_w-1:0]    c_last_idx   = c_idx_w'((1 << LOG_SAMPLES) - 1);
  localparam logic [c_tmr_w-1:0]    c_settle_end = c_tmr_w'(SETTLE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]    c_wait_end   = c_tmr_w'(CAPTURE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] c_one        = DATA_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  c_full       = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_SAMPLE = 3'd5,
    S_ACCUM  = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  state_t                  r_state;
  logic [c_tmr_w-1:0]      r_tmr;
  logic [c_idx_w-1:0]      r_idx;
  logic [DATA_WIDTH-1:0]   r_dout_q;
  logic [c_sum_w-1:0]      r_sum;
  logic [CNT_WIDTH-1:0]    r_min;
  logic [CNT_WIDTH-1:0]    r_max;
  logic                    r_bubble;
  logic                    r_ovf;
  logic                    r_resp_valid;
  logic                    r_tdc_reset_b;
  logic                    r_tdc_start;

  logic [CNT_WIDTH-1:0]    w_count;
  logic                    w_bubble;
  logic                    w_ovf;

  always_comb begin
`ifdef TDC_MEAS_CTRL_BUBBLE_FIX_EN
    w_count = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_count = w_count + CNT_WIDTH'(r_dout_q[i]);
`else
    // Scan downward so the lowest clear bit wins.
    w_count = c_full;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      if (!r_dout_q[i]) w_count = CNT_WIDTH'(i);
`endif
    // A clean thermometer code is 2^k-1, so it shares no set bit with itself+1.
    w_bubble = |(r_dout_q & (r_dout_q + c_one));
    w_ovf    = (w_count == c_full);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_idx         <= '0;
      r_dout_q      <= '0;
      r_sum         <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_bubble      <= 1'b0;
      r_ovf         <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_tdc_reset_b <= 1'b0;
      r_tdc_start   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_state  <= S_CLEAR;
          r_idx    <= '0;
          r_sum    <= '0;
          r_min    <= '1;
          r_max    <= '0;
          r_bubble <= 1'b0;
          r_ovf    <= 1'b0;
        end
        S_CLEAR: begin
          r_state       <= S_SETTLE;
          r_tmr         <= '0;
          r_tdc_reset_b <= 1'b1;
        end
        S_SETTLE: begin
          if (r_tmr == c_settle_end) r_state <= S_LAUNCH;
          else                       r_tmr   <= r_tmr + 1'b1;
        end
        S_LAUNCH: begin
          r_state     <= S_WAIT;
          r_tmr       <= '0;
          r_tdc_start <= 1'b1;
        end
        S_WAIT: begin
          if (r_tmr == c_wait_end) r_state <= S_SAMPLE;
          else                     r_tmr   <= r_tmr + 1'b1;
        end
        S_SAMPLE: begin
          r_dout_q      <= tdc_dout;
          r_state       <= S_ACCUM;
          r_tdc_reset_b <= 1'b0;
          r_tdc_start   <= 1'b0;
        end
        S_ACCUM: begin
          r_sum    <= r_sum + c_sum_w'(w_count);
          if (w_count < r_min) r_min <= w_count;
          if (w_count > r_max) r_max <= w_count;
          r_bubble <= r_bubble | w_bubble;
          r_ovf    <= r_ovf | w_ovf;
          if (r_idx == c_last_idx) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_RESP: if (resp_ready) begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_sum    = r_sum;
  assign resp_min    = r_min;
  assign resp_max    = r_max;
  assign resp_bubble = r_bubble;
  assign resp_ovf    = r_ovf;
  assign tdc_reset_b = r_tdc_reset_b;
  assign tdc_start   = r_tdc_start;

endmodule

`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
// ============================================================================
// Module   : tb_tdc_meas_ctrl
// Brief    : Self-checking bench for tdc_meas_ctrl with a thermometer TDC model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdc_meas_ctrl;

  localparam int DW = 252;

  logic          clk;
  logic          reset_b;
  logic          req_valid;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [9:0]    resp_sum;
  logic [7:0]    resp_min;
  logic [7:0]    resp_max;
  logic          resp_bubble;
  logic          resp_ovf;
  logic          busy;
  logic          tdc_reset_b;
  logic          tdc_start;
  logic [DW-1:0] tdc_dout;

  tdc_meas_ctrl dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_sum    (resp_sum),
    .resp_min    (resp_min),
    .resp_max    (resp_max),
    .resp_bubble (resp_bubble),
    .resp_ovf    (resp_ovf),
    .busy        (busy),
    .tdc_reset_b (tdc_reset_b),
    .tdc_start   (tdc_start),
    .tdc_dout    (tdc_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [3:0][DW-1:0] pat;
    logic [9:0]         sum;
    logic [7:0]         mn;
    logic [7:0]         mx;
    logic               bub;
    logic               ovf;
  } vec_t;

  vec_t               vecs[5];
  logic [3:0][DW-1:0] cur_pat;
  int                 checks   = 0;
  int                 failures = 0;
  int                 smp      = 0;
  logic               start_q  = 1'b0;

  // TDC model: cleared while tdc_reset_b is low, shows the current sample's
  // thermometer code while tdc_start is high; next sample after start falls.
  always @(negedge clk) begin
    if (!busy) smp = 0;
    else if (start_q && !tdc_start && smp < 3) smp = smp + 1;
    start_q = tdc_start;
    if (!tdc_reset_b)   tdc_dout = '0;
    else if (tdc_start) tdc_dout = cur_pat[smp[1:0]];
  end

  function automatic logic [DW-1:0] therm(input int n);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request with pattern set vi, check per-cycle TDC control
  // waveform and response latency; returns with the DUT holding RESP.
  task automatic run_req(input int vi);
    int n;
    int k;
    int wave_err;
    logic exp_rb;
    logic exp_st;
    cur_pat = vecs[vi].pat;
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    wave_err = 0;
    do begin
      @(posedge clk);
      #1 n++;
      k = n % 16;
      exp_rb = (n < 64) && (k >= 1) && (k <= 14);
      exp_st = (n < 64) && (k >= 6) && (k <= 14);
      if (tdc_reset_b !== exp_rb || tdc_start !== exp_st || busy !== 1'b1 || req_ready !== 1'b0)
        wave_err++;
    end while (!resp_valid && n < 200);
    chk({vecs[vi].name, "_latency"}, n, 64);
    chk({vecs[vi].name, "_wave_errs"}, wave_err, 0);
    chk({vecs[vi].name, "_sum"}, resp_sum, vecs[vi].sum);
    chk({vecs[vi].name, "_min"}, resp_min, vecs[vi].mn);
    chk({vecs[vi].name, "_max"}, resp_max, vecs[vi].mx);
    chk({vecs[vi].name, "_bubble"}, resp_bubble, vecs[vi].bub);
    chk({vecs[vi].name, "_ovf"}, resp_ovf, vecs[vi].ovf);
  endtask

  task automatic complete(input string name);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_done_valid"}, resp_valid, 0);
    chk({name, "_done_ready"}, req_ready, 1);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] bub_pat;
    int            stall_err;

    bub_pat = therm(10) | (therm(2) << 11);
    vecs[0] = '{"t37",   {4{therm(37)}},                           10'd148, 8'd37, 8'd37,  1'b0, 1'b0};
    vecs[1] = '{"ramp",  {therm(DW), therm(30), therm(20), therm(10)}, 10'd312, 8'd10, 8'd252, 1'b0, 1'b1};
`ifdef TDC_MEAS_CTRL_BUBBLE_FIX_EN
    vecs[2] = '{"bubble", {4{bub_pat}},                            10'd48,  8'd12, 8'd12,  1'b1, 1'b0};
`else
    vecs[2] = '{"bubble", {4{bub_pat}},                            10'd40,  8'd10, 8'd10,  1'b1, 1'b0};
`endif
    vecs[3] = '{"zero",  {4{therm(0)}},                            10'd0,   8'd0,  8'd0,   1'b0, 1'b0};
    vecs[4] = '{"mixed", {therm(251), therm(1), therm(DW), therm(0)}, 10'd504, 8'd0,  8'd252, 1'b0, 1'b1};

    reset_b    = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    cur_pat    = '0;
    tdc_dout   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_tdc_reset_b", tdc_reset_b, 0);
    chk("rst_tdc_start", tdc_start, 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sum", resp_sum, 0);
    chk("post_rst_min", resp_min, 0);
    chk("post_rst_max", resp_max, 0);
    chk("post_rst_flags", {resp_bubble, resp_ovf}, 0);
    chk("post_rst_tdc", {tdc_reset_b, tdc_start}, 0);

    for (int v = 0; v < 5; v++) begin
      run_req(v);
      complete(vecs[v].name);
    end

    // Back-pressure: RESP holds for 20 cycles, req_valid pulses ignored.
    run_req(0);
    stall_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = (i % 3 == 0);
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_sum !== 10'd148 ||
          resp_min !== 8'd37 || resp_max !== 8'd37 || busy !== 1'b1)
        stall_err++;
    end
    req_valid = 1'b0;
    chk("stall_errs", stall_err, 0);
    complete("stall");
    chk("stall_sum_kept", resp_sum, 148);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_idle_busy", busy, 0);

    // Asynchronous reset during WAIT of the second sample.
    cur_pat = vecs[0].pat;
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    chk("abort_pre_start", tdc_start, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("abort_tdc_start", tdc_start, 0);
    chk("abort_tdc_reset_b", tdc_reset_b, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    run_req(0);
    complete("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
